// File: rtl/score_pkg.sv
// Shared types, key codes and default geometry for the score tally block.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_CLEAR = 8'h01;

  localparam int unsigned Y_MAX_DEF     = 400;
  localparam int unsigned ARROW_H_DEF   = 40;
  localparam int unsigned SCORE_MAX_DEF = 9999;

  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned DD_W       = BIN_W + BCD_W;
  localparam logic [3:0]  LAST_SHIFT = 4'(BIN_W - 1);

  // One double-dabble iteration on {bcd[15:0], bin[13:0]}: add 3 to any
  // digit of 5 or more, then shift the whole register left by one.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] s);
    logic [DD_W-1:0] a;
    a = s;
    for (int unsigned d = 0; d < 4; d++) begin
      if (a[BIN_W + 4*d +: 4] >= 4'd5)
        a[BIN_W + 4*d +: 4] = a[BIN_W + 4*d +: 4] + 4'd3;
    end
    return {a[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/score_tally_bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter: one load cycle followed
// by 14 shift cycles; the result register only changes on completion.
module bin_to_bcd14
  import score_pkg::*;
(
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        clear,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t     state_q, state_d;
  logic [3:0]      cnt_q;
  logic [DD_W-1:0] sreg_q;
  logic [DD_W-1:0] sreg_step;
  logic [15:0]     bcd_q;

  assign sreg_step = dd_step(sreg_q);

  // Converter state register.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) state_q <= CONV_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a start is accepted while idle or in the completion cycle.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = CONV_IDLE;
    end else begin
      unique case (state_q)
        CONV_IDLE, CONV_DONE: state_d = start ? CONV_SHIFT : CONV_IDLE;
        CONV_SHIFT:           if (cnt_q == LAST_SHIFT) state_d = CONV_DONE;
        default:              state_d = CONV_IDLE;
      endcase
    end
  end

  // Shift register, shift counter and result register.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      bcd_q  <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      bcd_q  <= '0;
    end else if (state_q != CONV_SHIFT) begin
      if (start) begin
        sreg_q <= {16'h0000, bin};
        cnt_q  <= '0;
      end
    end else begin
      sreg_q <= sreg_step;
      cnt_q  <= cnt_q + 4'd1;
      if (cnt_q == LAST_SHIFT) bcd_q <= sreg_step[DD_W-1:BIN_W];
    end
  end

  assign busy = (state_q == CONV_SHIFT);
  assign done = (state_q == CONV_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_tally.sv
// Dropper consumer: resolves each arrow once as hit or miss, keeps game
// statistics and a saturating score, and publishes the score as BCD.
module score_tally
  import score_pkg::*;
#(
  parameter int unsigned N_DROPS   = 8,
  parameter int unsigned POINTS    = 10,
  parameter int unsigned Y_MAX     = Y_MAX_DEF,
  parameter int unsigned ARROW_H   = ARROW_H_DEF,
  parameter int unsigned SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [7:0]           keycode_second,
  input  logic [N_DROPS-1:0]   score_in,
  input  logic [N_DROPS*10-1:0] drop_y,
  output logic [7:0]           hit_count,
  output logic [7:0]           miss_count,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic [15:0]          score_bcd,
  output logic                 score_valid,
  output logic                 game_over,
  output logic [1:0]           state_out
);

  localparam int unsigned CW = $clog2(N_DROPS + 1);

  game_state_t        state_q, state_d;
  logic [N_DROPS-1:0] resolved_q, hit_v, miss_v;
  logic [CW-1:0]      h_cnt, m_cnt;
  logic [7:0]         hit_q, miss_q, combo_q, maxc_q;
  logic [7:0]         hit_d, miss_d, combo_d, maxc_d;
  logic [8:0]         hit_sum, miss_sum, combo_sum;
  logic [13:0]        score_q, score_d;
  logic [17:0]        score_sum;
  logic [15:0]        bcd_q, conv_bcd;
  logic               pending_q, valid_q;
  logic               key_start, key_clear, start_game, score_chg;
  logic               conv_start, conv_busy, conv_done, commit;

  assign key_start  = (keycode == KEY_START) || (keycode_second == KEY_START);
  assign key_clear  = (keycode == KEY_CLEAR) || (keycode_second == KEY_CLEAR);
  assign start_game = (state_q == IDLE) && key_start;

  // Game state register.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Game next state; DONE follows the cycle in which resolved[] fills up.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (key_start) state_d = PLAY;
      PLAY:    if (key_clear) state_d = IDLE;
               else if (&resolved_q) state_d = DONE;
      DONE:    if (key_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New hit/miss events for unresolved droppers, plus their popcounts.
  always_comb begin
    hit_v  = '0;
    miss_v = '0;
    h_cnt  = '0;
    m_cnt  = '0;
    for (int unsigned i = 0; i < N_DROPS; i++) begin
      if ((state_q == PLAY) && !resolved_q[i]) begin
        hit_v[i]  = score_in[i];
        miss_v[i] = !score_in[i] &&
                    (({1'b0, drop_y[10*i +: 10]} + 11'(ARROW_H)) >= 11'(Y_MAX));
      end
      h_cnt = h_cnt + CW'(hit_v[i]);
      m_cnt = m_cnt + CW'(miss_v[i]);
    end
  end

  // Saturating statistics and score for this cycle's events.
  always_comb begin
    hit_sum   = {1'b0, hit_q} + 9'(h_cnt);
    miss_sum  = {1'b0, miss_q} + 9'(m_cnt);
    combo_sum = {1'b0, combo_q} + 9'(h_cnt);
    hit_d     = hit_sum[8] ? 8'hff : hit_sum[7:0];
    miss_d    = miss_sum[8] ? 8'hff : miss_sum[7:0];
    combo_d   = (m_cnt != '0) ? 8'h00 : (combo_sum[8] ? 8'hff : combo_sum[7:0]);
    maxc_d    = (combo_d > maxc_q) ? combo_d : maxc_q;
    score_sum = 18'(score_q) + 18'(h_cnt) * 18'(POINTS);
    score_d   = (score_sum > 18'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
  end

  // A change that arrives mid-conversion is remembered in pending_q; the
  // stale result is then discarded and the converter reloads with the
  // current score in its completion cycle.
  assign score_chg  = (score_d != score_q);
  assign conv_start = !conv_busy && (score_chg || pending_q) && !start_game;
  assign commit     = conv_done && !pending_q;

  // Statistics, resolution flags and score bookkeeping.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      resolved_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      combo_q    <= '0;
      maxc_q     <= '0;
      score_q    <= '0;
      bcd_q      <= '0;
      pending_q  <= 1'b0;
      valid_q    <= 1'b1;
    end else if (start_game) begin
      resolved_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      combo_q    <= '0;
      maxc_q     <= '0;
      score_q    <= '0;
      bcd_q      <= '0;
      pending_q  <= 1'b0;
      valid_q    <= 1'b1;
    end else begin
      resolved_q <= resolved_q | hit_v | miss_v;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      combo_q    <= combo_d;
      maxc_q     <= maxc_d;
      score_q    <= score_d;
      pending_q  <= conv_busy ? (pending_q | score_chg) : 1'b0;
      if (commit) bcd_q <= conv_bcd;
      if (score_chg)   valid_q <= 1'b0;
      else if (commit) valid_q <= 1'b1;
    end
  end

  bin_to_bcd14 u_bcd (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (start_game),
    .start     (conv_start),
    .bin       (score_d),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (conv_bcd)
  );

  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign combo       = combo_q;
  assign max_combo   = maxc_q;
  assign score_bcd   = commit ? conv_bcd : bcd_q;
  assign score_valid = valid_q | commit;
  assign game_over   = (state_q == DONE);
  assign state_out   = state_q;

endmodule
